fifo_wr_ctrl: RTL and testbench



---
 rtl/fifo_wr_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the dual-clock FIFO: two-requester round-robin arbiter,
// binary/Gray write pointer, read-pointer synchroniser and registered fill status.
module fifo_wr_ctrl #(
    parameter int FIFO_data_size = 3,
    parameter int FIFO_addr_size = 2,
    parameter int AFULL_THRESH   = 3
) (
    input  logic                      clk_w,
    input  logic                      rst_w,
    input  logic                      req0,
    input  logic                      req1,
    input  logic [FIFO_data_size-1:0] data0,
    input  logic [FIFO_data_size-1:0] data1,
    output logic                      gnt0,
    output logic                      gnt1,
    input  logic [FIFO_addr_size:0]   rd_ptr_gray,
    output logic                      w_en,
    output logic [FIFO_addr_size-1:0] w_addr,
    output logic [FIFO_data_size-1:0] data_in,
    output logic                      full,
    output logic                      almost_full,
    output logic [FIFO_addr_size:0]   wr_level,
    output logic [FIFO_addr_size:0]   wr_ptr_gray
);

    localparam int PW = FIFO_addr_size + 1;
    // Inverting the top two Gray bits of the read pointer gives the write pointer
    // that is exactly one full lap ahead.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rq1_q, rq2_q;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_q, level_d;
    logic          rr_q, rr_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        rr_d = rr_q;
        // Grants are gated by reset so they read 0 while reset is held,
        // even though the requests are still active.
        if (rst_w && !full_q) begin
            gnt0 = req0 && (!req1 || !rr_q);
            gnt1 = req1 && (!req0 ||  rr_q);
        end
        if (gnt0) rr_d = 1'b1;
        if (gnt1) rr_d = 1'b0;
    end

    always_comb begin
        rbin_s       = '0;
        rbin_s[PW-1] = rq2_q[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ rq2_q[i];
        end
    end

    assign w_en    = gnt0 | gnt1;
    assign data_in = gnt0 ? data0 : (gnt1 ? data1 : '0);

    assign wbin_d  = wbin_q + PW'(w_en);
    assign wgray_d = wbin_d ^ (wbin_d >> 1);
    // Unsigned subtraction at pointer width absorbs wrap-around.
    assign level_d = wbin_d - rbin_s;
    assign full_d  = (wgray_d == (rq2_q ^ FULL_MASK));
    assign afull_d = (level_d >= PW'(AFULL_THRESH));

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from pre-edge values, which the two-flop synchroniser depends on.
    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            rr_q    <= 1'b0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            level_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= rd_ptr_gray;
            rq2_q   <= rq1_q;
            rr_q    <= rr_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            level_q <= level_d;
        end
    end

    assign w_addr      = wbin_q[FIFO_addr_size-1:0];
    assign wr_ptr_gray = wgray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed testbench for fifo_wr_ctrl with default parameters (3-bit data, depth 4,
// almost_full threshold 3); expected values are hand-computed constants.
module tb_fifo_wr_ctrl;

    logic       clk_w = 1'b0;
    logic       rst_w;
    logic       req0, req1;
    logic [2:0] data0, data1;
    logic       gnt0, gnt1;
    logic [2:0] rd_ptr_gray;
    logic       w_en;
    logic [1:0] w_addr;
    logic [2:0] data_in;
    logic       full, almost_full;
    logic [2:0] wr_level;
    logic [2:0] wr_ptr_gray;

    int checks = 0;
    int errors = 0;

    fifo_wr_ctrl #(
        .FIFO_data_size(3),
        .FIFO_addr_size(2),
        .AFULL_THRESH  (3)
    ) dut (
        .clk_w      (clk_w),
        .rst_w      (rst_w),
        .req0       (req0),
        .req1       (req1),
        .data0      (data0),
        .data1      (data1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rd_ptr_gray(rd_ptr_gray),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .data_in    (data_in),
        .full       (full),
        .almost_full(almost_full),
        .wr_level   (wr_level),
        .wr_ptr_gray(wr_ptr_gray)
    );

    always #5 clk_w = ~clk_w;

    // Advance past one rising edge and settle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk_w);
        #1;
    endtask

    task automatic do_reset();
        rst_w       = 1'b0;
        req0        = 1'b0;
        req1        = 1'b0;
        data0       = '0;
        data1       = '0;
        rd_ptr_gray = '0;
        tick();
        tick();
        rst_w = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (full !== 1'b0)        begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
        checks++; if (wr_level !== 3'd0)    begin errors++; $display("FAIL reset_level got=%0d exp=0", wr_level); end
        checks++; if (w_addr !== 2'd0)      begin errors++; $display("FAIL reset_waddr got=%0d exp=0", w_addr); end
        checks++; if (wr_ptr_gray !== 3'd0) begin errors++; $display("FAIL reset_wgray got=%b exp=000", wr_ptr_gray); end
        checks++; if ({gnt0, gnt1, w_en} !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b exp=000", {gnt0, gnt1, w_en}); end
        tick();
        checks++; if (wr_level !== 3'd0)    begin errors++; $display("FAIL reset_idle_level got=%0d exp=0", wr_level); end
    endtask

    // Fill to full from requester 0, then drain one word and resume.
    task automatic test_fill_drain();
        logic [2:0] exp_gray [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
        do_reset();
        req0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data0 = 3'(i + 1);
            #1;
            checks++; if (gnt0 !== 1'b1 || w_en !== 1'b1) begin errors++; $display("FAIL fill_gnt[%0d] got gnt0=%b w_en=%b exp=1", i, gnt0, w_en); end
            checks++; if (w_addr !== 2'(i))  begin errors++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, w_addr, i); end
            checks++; if (data_in !== 3'(i + 1)) begin errors++; $display("FAIL fill_data[%0d] got=%0d exp=%0d", i, data_in, i + 1); end
            tick();
            checks++; if (wr_level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, wr_level, i + 1); end
            checks++; if (almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, i >= 2); end
            checks++; if (full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 3); end
            checks++; if (wr_ptr_gray !== exp_gray[i]) begin errors++; $display("FAIL fill_wgray[%0d] got=%b exp=%b", i, wr_ptr_gray, exp_gray[i]); end
        end
        data0 = 3'd5;
        #1;
        checks++; if (gnt0 !== 1'b0 || w_en !== 1'b0) begin errors++; $display("FAIL full_blocks got gnt0=%b w_en=%b exp=0", gnt0, w_en); end
        checks++; if (data_in !== 3'd0) begin errors++; $display("FAIL full_data got=%0d exp=0", data_in); end
        tick();
        checks++; if (full !== 1'b1 || wr_level !== 3'd4) begin errors++; $display("FAIL full_hold got full=%b level=%0d exp 1/4", full, wr_level); end

        // Drain: read pointer advances to Gray(1) with requester 0 still waiting.
        rd_ptr_gray = 3'b001;
        tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL drain_lag1 got full=%b exp=1", full); end
        tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL drain_lag2 got full=%b exp=1", full); end
        checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL drain_lag2_gnt got=%b exp=0", gnt0); end
        tick();
        checks++; if (full !== 1'b0 || wr_level !== 3'd3) begin errors++; $display("FAIL drain_flags got full=%b level=%0d exp 0/3", full, wr_level); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL drain_afull got=%b exp=1", almost_full); end
        checks++; if (gnt0 !== 1'b1 || w_addr !== 2'd0 || data_in !== 3'd5) begin errors++; $display("FAIL resume_write got gnt0=%b addr=%0d data=%0d exp 1/0/5", gnt0, w_addr, data_in); end
        tick();
        req0 = 1'b0;
        // wbin is now 5: address 1, Gray 111, level 4 again.
        checks++; if (w_addr !== 2'd1 || wr_ptr_gray !== 3'b111) begin errors++; $display("FAIL resume_ptr got addr=%0d gray=%b exp 1/111", w_addr, wr_ptr_gray); end
        checks++; if (full !== 1'b1 || wr_level !== 3'd4) begin errors++; $display("FAIL resume_full got full=%b level=%0d exp 1/4", full, wr_level); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] rd_seq [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
        rst_w = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 3'd5;
        data1 = 3'd2;
        rd_ptr_gray = '0;
        #1;
        checks++; if ({gnt0, gnt1, w_en} !== 3'b000) begin errors++; $display("FAIL b2b_in_reset got=%b exp=000", {gnt0, gnt1, w_en}); end
        tick();
        rst_w = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_gnt[%0d] got gnt0=%b gnt1=%b exp gnt0=%b", i, gnt0, gnt1, i % 2 == 0); end
            checks++; if (data_in !== ((i % 2 == 0) ? 3'd5 : 3'd2)) begin errors++; $display("FAIL b2b_data[%0d] got=%0d", i, data_in); end
            tick();
            rd_ptr_gray = rd_seq[i];
        end
        checks++; if (full !== 1'b0 || wr_ptr_gray !== 3'b110) begin errors++; $display("FAIL b2b_end got full=%b gray=%b exp 0/110", full, wr_ptr_gray); end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_wrap();
        logic [2:0] seq [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req0  = 1'b1;
            data0 = 3'(i);
            #1;
            checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL wrap_gnt[%0d] got=%b exp=1", i, gnt0); end
            tick();
            req0 = 1'b0;
            checks++; if (wr_ptr_gray !== seq[i]) begin errors++; $display("FAIL wrap_gray[%0d] got=%b exp=%b", i, wr_ptr_gray, seq[i]); end
            checks++; if (wr_level !== 3'd1 || full !== 1'b0) begin errors++; $display("FAIL wrap_level[%0d] got level=%0d full=%b exp 1/0", i, wr_level, full); end
            rd_ptr_gray = seq[i];
            tick();
            tick();
        end
        tick();
        checks++; if (wr_level !== 3'd0) begin errors++; $display("FAIL wrap_drained got=%0d exp=0", wr_level); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req1 = 1'b1;
        data1 = 3'd6;
        tick();
        data1 = 3'd7;
        tick();
        data1 = 3'd3;
        #1;
        checks++; if (wr_level !== 3'd2 || gnt1 !== 1'b1) begin errors++; $display("FAIL mid_pre got level=%0d gnt1=%b exp 2/1", wr_level, gnt1); end
        #2;
        rst_w = 1'b0;
        #1;
        checks++; if ({gnt0, gnt1, w_en, full, almost_full} !== 5'b0) begin errors++; $display("FAIL mid_flags got=%b exp=00000", {gnt0, gnt1, w_en, full, almost_full}); end
        checks++; if (wr_level !== 3'd0 || w_addr !== 2'd0 || wr_ptr_gray !== 3'd0 || data_in !== 3'd0) begin errors++; $display("FAIL mid_ptrs got level=%0d addr=%0d gray=%b data=%0d exp 0", wr_level, w_addr, wr_ptr_gray, data_in); end
        tick();
        rst_w = 1'b1;
        #1;
        checks++; if (gnt1 !== 1'b1 || w_addr !== 2'd0 || data_in !== 3'd3) begin errors++; $display("FAIL mid_resume got gnt1=%b addr=%0d data=%0d exp 1/0/3", gnt1, w_addr, data_in); end
        tick();
        req1 = 1'b0;
        checks++; if (w_addr !== 2'd1 || wr_level !== 3'd1) begin errors++; $display("FAIL mid_after got addr=%0d level=%0d exp 1/1", w_addr, wr_level); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
